// File: rtl/angle_gen_mc.sv
// Multi-channel angle / triangle / square generator feeding a CORDIC stage.
// Each channel advances on its own divided update strobe; config arrives via a valid/ready port.
module angle_gen_mc #(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned FREQ_WIDTH = 13,
    parameter int unsigned NCH        = 4,
    parameter int unsigned CNT        = 262144,
    parameter int unsigned AMP        = 2000,
    parameter int unsigned AN         = 1215,
    parameter int unsigned ASTEP0     = 31,
    parameter int unsigned TSTEP0     = 63,
    localparam int unsigned CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    sync,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CHW-1:0]          cfg_ch,
    input  logic [FREQ_WIDTH-1:0]   cfg_freq,
    input  logic [WIDTH-1:0]        cfg_astep,
    input  logic [WIDTH-1:0]        cfg_tstep,
    output logic                    cfg_err,
    output logic [WIDTH-1:0]        x_start,
    output logic [WIDTH-1:0]        y_start,
    output logic [NCH*WIDTH-1:0]    angle,
    output logic [NCH*WIDTH-1:0]    tri_amp,
    output logic [NCH*WIDTH-1:0]    sqr_amp,
    output logic [NCH-1:0]          tick
);

    localparam int unsigned CW = FREQ_WIDTH + 5;
    // Two guard bits so tri +/- tstep can never wrap, even for large steps.
    localparam int unsigned TW = WIDTH + 2;
    localparam logic [CW-1:0]        CNT_W  = CW'(CNT);
    localparam logic signed [TW-1:0] AMP_P  = TW'(AMP);
    localparam logic signed [TW-1:0] AMP_N  = TW'(-int'(AMP));
    localparam logic [WIDTH-1:0]     SQR_HI = WIDTH'(AMP - 1);
    localparam logic [WIDTH-1:0]     SQR_LO = WIDTH'(-int'(AMP));

    logic [CW-1:0]         cnt_q   [NCH];
    logic [CW-1:0]         cnt_d   [NCH];
    logic [FREQ_WIDTH-1:0] freq_q  [NCH];
    logic [FREQ_WIDTH-1:0] freq_d  [NCH];
    logic [WIDTH-1:0]      astep_q [NCH];
    logic [WIDTH-1:0]      astep_d [NCH];
    logic [WIDTH-1:0]      tstep_q [NCH];
    logic [WIDTH-1:0]      tstep_d [NCH];
    logic [WIDTH-1:0]      angle_q [NCH];
    logic [WIDTH-1:0]      angle_d [NCH];
    logic [WIDTH-1:0]      tri_q   [NCH];
    logic [WIDTH-1:0]      tri_d   [NCH];
    logic [WIDTH-1:0]      sqr_q   [NCH];
    logic [WIDTH-1:0]      sqr_d   [NCH];
    logic                  down_q  [NCH];
    logic                  down_d  [NCH];
    logic [CW-1:0]         limit   [NCH];
    logic signed [TW-1:0]  tsum    [NCH];
    logic signed [TW-1:0]  tdif    [NCH];
    logic [NCH-1:0]        tick_q, tick_d;
    logic                  cfg_ready_q, cfg_ready_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [WIDTH-1:0]      x_start_q, y_start_q;
    logic                  xfer, ch_ok;

    always_comb begin
        xfer        = cfg_valid && cfg_ready_q;
        ch_ok       = 32'(cfg_ch) < NCH;
        cfg_ready_d = !xfer;
        cfg_err_d   = xfer && !ch_ok;
        tick_d      = '0;
        for (int ch = 0; ch < int'(NCH); ch++) begin
            cnt_d[ch]   = cnt_q[ch];
            freq_d[ch]  = freq_q[ch];
            astep_d[ch] = astep_q[ch];
            tstep_d[ch] = tstep_q[ch];
            angle_d[ch] = angle_q[ch];
            tri_d[ch]   = tri_q[ch];
            down_d[ch]  = down_q[ch];
            sqr_d[ch]   = tri_q[ch][WIDTH-1] ? SQR_LO : SQR_HI;
            limit[ch]   = CNT_W - {freq_q[ch], 5'b0};
            tsum[ch]    = $signed({{2{tri_q[ch][WIDTH-1]}}, tri_q[ch]})
                          + $signed({2'b00, tstep_q[ch]});
            tdif[ch]    = $signed({{2{tri_q[ch][WIDTH-1]}}, tri_q[ch]})
                          - $signed({2'b00, tstep_q[ch]});

            if (xfer && ch_ok && cfg_ch == CHW'(ch)) begin
                freq_d[ch]  = cfg_freq;
                astep_d[ch] = cfg_astep;
                tstep_d[ch] = cfg_tstep;
                cnt_d[ch]   = '0;
            end else if (!sync && enable) begin
                if (cnt_q[ch] == limit[ch]) begin
                    cnt_d[ch]   = '0;
                    tick_d[ch]  = 1'b1;
                    angle_d[ch] = angle_q[ch] + astep_q[ch];
                    if (!down_q[ch]) begin
                        if (tsum[ch] >= AMP_P) begin
                            tri_d[ch]  = AMP_P[WIDTH-1:0];
                            down_d[ch] = 1'b1;
                        end else begin
                            tri_d[ch] = tsum[ch][WIDTH-1:0];
                        end
                    end else if (tdif[ch] <= AMP_N) begin
                        tri_d[ch]  = AMP_N[WIDTH-1:0];
                        down_d[ch] = 1'b0;
                    end else begin
                        tri_d[ch] = tdif[ch][WIDTH-1:0];
                    end
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 1'b1;
                end
            end

            // Sync clears phase state but still lets a coincident config load land.
            if (sync) begin
                cnt_d[ch]   = '0;
                angle_d[ch] = '0;
                tri_d[ch]   = '0;
                down_d[ch]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            tick_q      <= '0;
            x_start_q   <= '0;
            y_start_q   <= '0;
            for (int ch = 0; ch < int'(NCH); ch++) begin
                cnt_q[ch]   <= '0;
                freq_q[ch]  <= '0;
                astep_q[ch] <= WIDTH'(ASTEP0);
                tstep_q[ch] <= WIDTH'(TSTEP0);
                angle_q[ch] <= '0;
                tri_q[ch]   <= '0;
                sqr_q[ch]   <= '0;
                down_q[ch]  <= 1'b0;
            end
        end else begin
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            tick_q      <= tick_d;
            x_start_q   <= WIDTH'(AN);
            y_start_q   <= '0;
            for (int ch = 0; ch < int'(NCH); ch++) begin
                cnt_q[ch]   <= cnt_d[ch];
                freq_q[ch]  <= freq_d[ch];
                astep_q[ch] <= astep_d[ch];
                tstep_q[ch] <= tstep_d[ch];
                angle_q[ch] <= angle_d[ch];
                tri_q[ch]   <= tri_d[ch];
                sqr_q[ch]   <= sqr_d[ch];
                down_q[ch]  <= down_d[ch];
            end
        end
    end

    for (genvar g = 0; g < int'(NCH); g++) begin : g_out
        assign angle[g*WIDTH +: WIDTH]   = angle_q[g];
        assign tri_amp[g*WIDTH +: WIDTH] = tri_q[g];
        assign sqr_amp[g*WIDTH +: WIDTH] = sqr_q[g];
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign tick      = tick_q;
    assign x_start   = x_start_q;
    assign y_start   = y_start_q;

endmodule
